// File: rtl/didactic_selftest_pkg.sv
// Shared definitions for the Didactic GPIO loopback self-test engine.
//   - state_e      : run-control states (IDLE, PRIME, RUN, DONE)
//   - LFSR_W/TAP_* : pattern generator width and feedback taps
//   - DEFAULT_SEED : power-up LFSR value
//   - MAX_CH       : widest channel vector supported (first_err_ch is 5 bits)
//   - lowest_set() : index of the lowest set bit in a channel vector
package didactic_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LFSR_W = 32;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (bit positions, 0-based)
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_0001;

  localparam int MAX_CH = 32;

  // Lowest-index set bit; returns 0 for an all-zero vector.
  function automatic logic [4:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/selftest_lfsr.sv
// 32-bit Fibonacci LFSR used as the loopback pattern source.
// Shifts left; the new bit 0 is the XOR of the four feedback taps.
// Ports:
//   clk_in  : clock
//   reset   : synchronous active-high reset (loads RESET_VAL)
//   load_i  : load seed_i this cycle (has priority over en_i)
//   seed_i  : value loaded by load_i
//   en_i    : advance one step
//   q_o     : current LFSR state
module selftest_lfsr
  import didactic_selftest_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              feedback;

  assign feedback = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], feedback};
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/didactic_io_selftest.sv
// GPIO loopback self-test engine for Didactic board bring-up.
// Drives an LFSR pattern on gpio_out, compares the looped-back gpio_in
// against a LOOP_LAT-delayed copy of the pattern for RUN_CYCLES cycles and
// keeps a saturating per-channel error count.
// Ports:
//   clk_in, reset   : clock, synchronous active-high reset
//   start_i         : start a run (accepted in IDLE or DONE)
//   abort_i         : return to IDLE, results held (wins over start_i)
//   inject_i        : flip gpio_out[0] this cycle (RUN only)
//   gpio_in         : looped-back channels (already synchronous to clk_in)
//   gpio_out/oe     : pattern and its output enable
//   busy/done/pass  : run status
//   err_count       : channel k at [k*ERR_W +: ERR_W]
//   first_err_ch/vld: lowest failing channel on the first failing compare
module didactic_io_selftest
  import didactic_selftest_pkg::*;
#(
  parameter int                N_CH       = 8,
  parameter int                LOOP_LAT   = 2,
  parameter int                RUN_CYCLES = 1000,
  parameter int                ERR_W      = 8,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  inject_i,
  input  logic [N_CH-1:0]       gpio_in,
  output logic [N_CH-1:0]       gpio_out,
  output logic                  gpio_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_CH*ERR_W-1:0] err_count,
  output logic [4:0]            first_err_ch,
  output logic                  first_err_vld
);

  localparam int CNT_MAX = (LOOP_LAT > RUN_CYCLES) ? LOOP_LAT : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(LOOP_LAT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);

  state_e                           state_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             pass_q;
  logic                             first_vld_q;
  logic [4:0]                       first_ch_q;
  logic [LOOP_LAT-1:0][N_CH-1:0]    exp_pipe_q;

  logic [LFSR_W-1:0] lfsr_q;
  logic [N_CH-1:0]   pattern;
  logic [N_CH-1:0]   exp_bits;
  logic [N_CH-1:0]   mism;
  logic [N_CH-1:0]   err_nz_d;
  logic              active;
  logic              in_run;
  logic              restart;
  logic              compare_en;
  logic              unused_lfsr_bits;

  assign active     = (state_q == PRIME) || (state_q == RUN);
  assign in_run     = (state_q == RUN);
  assign restart    = ((state_q == IDLE) || (state_q == DONE)) && start_i && !abort_i;
  // An aborting RUN cycle does not count: the results freeze as they stood.
  assign compare_en = in_run && !abort_i;

  assign pattern          = lfsr_q[N_CH-1:0];
  assign unused_lfsr_bits = ^lfsr_q;

  selftest_lfsr #(
    .RESET_VAL(SEED)
  ) u_lfsr (
    .clk_in(clk_in),
    .reset (reset),
    .load_i(restart),
    .seed_i(SEED),
    .en_i  (active),
    .q_o   (lfsr_q)
  );

  // Expected-value chain: fed with the un-injected pattern so an injected
  // fault on gpio_out shows up as a mismatch LOOP_LAT cycles later.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      exp_pipe_q <= '0;
    end else if (active) begin
      exp_pipe_q[0] <= pattern;
      for (int i = 1; i < LOOP_LAT; i++) begin
        exp_pipe_q[i] <= exp_pipe_q[i-1];
      end
    end
  end

  assign exp_bits = exp_pipe_q[LOOP_LAT-1];
  assign mism     = (gpio_in ^ exp_bits) & {N_CH{compare_en}};

  // Per-channel saturating error counters.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ERR_W-1:0] err_q;
      logic [ERR_W-1:0] err_d;

      always_comb begin
        err_d = err_q;
        if (restart) begin
          err_d = '0;
        end else if (mism[gi] && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + 1'b1;
        end
      end

      always_ff @(posedge clk_in) begin
        if (reset) begin
          err_q <= '0;
        end else begin
          err_q <= err_d;
        end
      end

      assign err_nz_d[gi]                 = |err_d;
      assign err_count[gi*ERR_W +: ERR_W] = err_q;
    end
  endgenerate

  // Run control with registered status outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= PRIME;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
          end
        end
        PRIME: begin
          if (cnt_q == PRIME_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if ((|mism) && !first_vld_q) begin
            first_vld_q <= 1'b1;
            first_ch_q  <= lowest_set(MAX_CH'(mism));
          end
          if (cnt_q == RUN_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Uses next-state counts so the final compare is included.
            pass_q  <= ~|err_nz_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gpio_out      = active ? (pattern ^ N_CH'(inject_i && in_run)) : '0;
  assign gpio_oe       = busy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign first_err_ch  = first_ch_q;
  assign first_err_vld = first_vld_q;

endmodule

// File: tb/tb_didactic_io_selftest.sv
// Self-checking bench for didactic_io_selftest (default parameters).
// A board-level loopback model feeds gpio_out back to gpio_in with a chosen
// delay, optional stuck channel and random bit flips; expected results are
// derived from the LFSR sequence and the recorded gpio_in values.
module tb_didactic_io_selftest;

  localparam int          N_CH   = 8;
  localparam int          LAT    = 2;
  localparam int          RUNC   = 1000;
  localparam int          ERR_W  = 8;
  localparam int          TOTAL  = LAT + RUNC;
  localparam int          SAT    = (1 << ERR_W) - 1;
  localparam logic [31:0] SEED_V = 32'hACE1_0001;

  logic                  clk_in = 1'b0;
  logic                  reset;
  logic                  start_i;
  logic                  abort_i;
  logic                  inject_i;
  logic [N_CH-1:0]       gpio_in;
  logic [N_CH-1:0]       gpio_out;
  logic                  gpio_oe;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [N_CH*ERR_W-1:0] err_count;
  logic [4:0]            first_err_ch;
  logic                  first_err_vld;

  int n_vec = 0;
  int n_bad = 0;

  logic [N_CH-1:0] pat     [TOTAL];
  logic [N_CH-1:0] hist    [TOTAL];
  logic [N_CH-1:0] gin_rec [RUNC];
  bit              inj     [TOTAL];
  int              held_cnt[N_CH];

  didactic_io_selftest dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .inject_i     (inject_i),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_err_ch (first_err_ch),
    .first_err_vld(first_err_vld)
  );

  always #5 clk_in = ~clk_in;

  // x^32+x^22+x^2+x+1: feedback is the parity of bits 31, 21, 1 and 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".flags"}, 64'({gpio_oe, busy, done, pass}), 64'd0);
    check_eq({tag, ".gpio_out"}, 64'(gpio_out), 64'd0);
  endtask

  // Error statistics over the first ncmp compares, then compare with the DUT.
  task automatic model_and_check(input string tag, input int ncmp, input bit exp_done);
    int              cnt[N_CH];
    bit              fv;
    int              fch;
    bit              allz;
    logic [N_CH-1:0] m;
    fv   = 1'b0;
    fch  = 0;
    allz = 1'b1;
    for (int k = 0; k < N_CH; k++) cnt[k] = 0;
    for (int j = 0; j < ncmp; j++) begin
      m = gin_rec[j] ^ pat[j];
      for (int k = 0; k < N_CH; k++) begin
        if (m[k] && cnt[k] < SAT) cnt[k]++;
      end
      if (m != '0 && !fv) begin
        fv = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) if (m[k]) fch = k;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (cnt[k] != 0) allz = 1'b0;
      held_cnt[k] = cnt[k];
      check_eq($sformatf("%s.err[%0d]", tag, k), 64'(err_count[k*ERR_W +: ERR_W]), 64'(cnt[k]));
    end
    check_eq({tag, ".first_vld"}, 64'(first_err_vld), 64'(fv));
    if (fv) check_eq({tag, ".first_ch"}, 64'(first_err_ch), 64'(fch));
    check_eq({tag, ".done"}, 64'(done), 64'(exp_done));
    check_eq({tag, ".pass"}, 64'(pass), 64'(exp_done && allz));
    check_eq({tag, ".busy"}, 64'({busy, gpio_oe}), 64'd0);
    $display("run %s: compares=%0d first_vld=%0d first_ch=%0d pass=%0d", tag, ncmp, fv, fch, pass);
  endtask

  task automatic run_test(input string tag, input int dly, input int stuck_ch, input int n_inj,
                          input int flip_pm, input int abort_at, input int reset_at,
                          input bit busy_start);
    logic [N_CH-1:0] g;
    int              placed;
    int              c;
    int              stop_at;
    placed  = 0;
    stop_at = -1;
    for (int i = 0; i < TOTAL; i++) inj[i] = 1'b0;
    while (placed < n_inj) begin
      c = int'($urandom_range(TOTAL - 10, LAT));
      if (!inj[c]) begin
        inj[c] = 1'b1;
        placed++;
      end
    end
    start_i = 1'b1;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < TOTAL; i++) begin
      abort_i  = (i == abort_at);
      reset    = (i == reset_at);
      inject_i = inj[i];
      start_i  = busy_start && (i == LAT + 37);
      #1;
      check_eq($sformatf("%s.gpio_out[%0d]", tag, i), 64'(gpio_out), 64'(pat[i] ^ N_CH'(inj[i])));
      check_eq($sformatf("%s.flags[%0d]", tag, i), 64'({gpio_oe, busy, done}), 64'b110);
      hist[i] = gpio_out;
      g = (i >= dly) ? hist[i-dly] : '0;
      if (i != abort_at) begin
        for (int k = 0; k < N_CH; k++) begin
          if (int'($urandom_range(999)) < flip_pm) g[k] = ~g[k];
        end
      end
      if (stuck_ch >= 0) g[stuck_ch] = 1'b0;
      gpio_in = g;
      if (i >= LAT) gin_rec[i-LAT] = g;
      @(posedge clk_in);
      #1;
      if (i == abort_at || i == reset_at) begin
        stop_at = i;
        break;
      end
    end
    if (stop_at >= 0) begin
      check_idle(tag);
      if (stop_at == reset_at) begin
        for (int k = 0; k < N_CH; k++) begin
          held_cnt[k] = 0;
          check_eq($sformatf("%s.err[%0d]", tag, k), 64'(err_count[k*ERR_W +: ERR_W]), 64'd0);
        end
        check_eq({tag, ".first"}, 64'({first_err_vld, first_err_ch}), 64'd0);
        $display("run %s: reset at cycle %0d", tag, stop_at);
      end else begin
        model_and_check(tag, stop_at - LAT, 1'b0);
      end
    end else begin
      model_and_check(tag, RUNC, 1'b1);
    end
    abort_i  = 1'b0;
    reset    = 1'b0;
    start_i  = 1'b0;
    inject_i = 1'b0;
    gpio_in  = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    s = SEED_V;
    for (int i = 0; i < TOTAL; i++) begin
      pat[i] = s[N_CH-1:0];
      s      = lfsr_next(s);
    end

    reset    = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    inject_i = 1'b0;
    gpio_in  = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_idle("reset");
    check_eq("reset.err", 64'(err_count), 64'd0);
    check_eq("reset.first", 64'({first_err_vld, first_err_ch}), 64'd0);
    reset = 1'b0;
    @(posedge clk_in);
    #1;

    run_test("ideal",       2, -1, 0, 0, -1,        -1,        1'b0);
    run_test("inject3",     2, -1, 3, 0, -1,        -1,        1'b0);
    run_test("stuck5",      2,  5, 0, 0, -1,        -1,        1'b0);
    run_test("delay3",      3, -1, 0, 0, -1,        -1,        1'b0);
    run_test("random",      2, -1, 0, 4, -1,        -1,        1'b1);
    run_test("abort",       2, -1, 0, 5, LAT + 100, -1,        1'b0);
    run_test("after_abort", 2, -1, 0, 0, -1,        -1,        1'b0);
    run_test("reset_mid",   2, -1, 0, 5, -1,        LAT + 300, 1'b0);
    run_test("final",       2, -1, 0, 2, -1,        -1,        1'b0);

    // start and abort together while DONE: abort wins, results held.
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_in);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    check_idle("start_abort");
    for (int k = 0; k < N_CH; k++) begin
      check_eq($sformatf("start_abort.err[%0d]", k), 64'(err_count[k*ERR_W +: ERR_W]), 64'(held_cnt[k]));
    end
    @(posedge clk_in);
    #1;
    check_idle("start_abort.next");
    $display("run start_abort: checked");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/didactic_io_selftest.md
Name: didactic_io_selftest

Overview:
- Synthesizable, parametrised loopback self-test engine for FPGA bring-up of the Didactic SoC.
- Drives a pseudo-random pattern onto N_CH GPIO channels and compares the looped-back inputs against a delayed copy of that pattern.
- Keeps a saturating error count per channel and reports pass/fail.
- Replaces the passive, stimulus-free top-level harness with a self-checking block that can be instantiated next to Didactic on the board.

Parameters:
- N_CH, 8, number of GPIO channels under test; range 1..32.
- LOOP_LAT, 2, loopback latency in clk_in cycles from gpio_out to gpio_in; must be >= 1.
- RUN_CYCLES, 1000, number of compare cycles per run; must be >= 1.
- ERR_W, 8, width of each per-channel error counter.
- SEED, 32'hACE1_0001, LFSR start value; must be nonzero.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; honoured only in IDLE or DONE.
- abort_i  in  1  abort the current run; returns to IDLE.
- inject_i  in  1  invert gpio_out[0] for this cycle; RUN state only.
- gpio_in  in  N_CH  looped-back channel inputs.
- gpio_out  out  N_CH  pattern output.
- gpio_oe  out  1  output enable, high in PRIME and RUN.
- busy  out  1  high in PRIME and RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when every error counter is zero.
- err_count  out  N_CH*ERR_W  per-channel error counters; channel k occupies bits [k*ERR_W +: ERR_W].
- first_err_ch  out  5  index of the lowest channel that mismatched on the first failing compare cycle.
- first_err_vld  out  1  first_err_ch is valid.

Behaviour:
- Reset values: all outputs 0; state = IDLE; LFSR = SEED; counters 0; delay line 0.
- LFSR:
  - 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - Shifts left each cycle; new bit0 = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0].
  - Advances only in PRIME and RUN.
- gpio_out:
  - PRIME and RUN: lfsr[N_CH-1:0], except bit 0 is XORed with inject_i in RUN.
  - IDLE and DONE: 0.
- Expected value: a LOOP_LAT-deep register chain fed with the un-injected lfsr[N_CH-1:0] in PRIME and RUN. Its output exp is the value gpio_in must match.
- FSM:
  - IDLE: start_i -> PRIME. On the transition, LFSR <- SEED, and err_count, first_err_vld and the cycle counter are cleared.
  - PRIME: lasts exactly LOOP_LAT cycles with no compares, then -> RUN.
  - RUN: compares gpio_in against exp every cycle. After RUN_CYCLES compares -> DONE.
  - DONE: holds done=1 and the results until start_i (-> PRIME, results cleared as above) or abort_i (-> IDLE).
  - abort_i in any state -> IDLE next cycle; err_count is held, done=0, pass=0. abort_i has priority over start_i.
  - start_i while busy is ignored.
- Cycle timing: start_i sampled high at edge t -> state PRIME from t+1, gpio_out = SEED[N_CH-1:0] at t+1, first compare at t+1+LOOP_LAT, done high at t+1+LOOP_LAT+RUN_CYCLES.
- Error counting:
  - In RUN, for each channel k where gpio_in[k] != exp[k], err_count[k] increments.
  - Counters saturate at 2^ERR_W-1 and never wrap.
  - first_err_ch/first_err_vld latch on the first RUN cycle with any mismatch (lowest-index channel) and stay fixed until the next start.
- pass = done & (all err_count == 0); registered, same cycle as done.
- gpio_in is treated as already synchronous to clk_in; the board wrapper provides any synchronizers.
- reset mid-run: immediate return to the reset values above; no partial results are kept.

Decomposition:
- Package didactic_selftest_pkg:
  - state enum {IDLE, PRIME, RUN, DONE} (2 bits);
  - LFSR_W=32;
  - LFSR tap positions;
  - DEFAULT_SEED;
  - MAX_CH=32.
- Sub-module selftest_lfsr: 32-bit LFSR with ports clk_in, reset, load_i, seed_i, en_i, q_o.
- The FSM, delay line and counters stay in the top module.

Test Plan:
- Ideal loopback (gpio_in = gpio_out delayed 2 cycles), defaults, start_i pulse -> done after 1+2+1000 cycles, pass=1, all err_count=0, first_err_vld=0.
- Same setup, inject_i pulsed for 3 separate RUN cycles -> err_count[0]=3, all other channels 0, pass=0, first_err_ch=0.
- Channel 5 stuck at 0, RUN_CYCLES=1000, ERR_W=8 -> err_count[5] saturates at 255, others 0, first_err_ch=5, pass=0.
- Loopback modelled with 3 cycles delay against LOOP_LAT=2 -> errors on all channels, first_err_vld on the first RUN cycle, first_err_ch = lowest mismatching bit.
- abort_i 100 cycles into RUN -> IDLE next cycle, gpio_oe=0, done=0; a subsequent start_i with ideal loopback -> pass=1 with counters cleared.
- reset asserted mid-RUN, start_i issued simultaneously in DONE with abort_i -> after reset all outputs 0; with the simultaneous pair, abort wins (IDLE).
